qpp_block_interleaver: RTL and testbench

- Parametrised successor to the coder-interleaver datapath: accepts a code block as a stream of DATA_W-bit words and emits two bit-serial streams, c[i] in natural order and c[pi(i)] in QPP-interleaved order.
- Two runtime-selectable block sizes.
- Ping-pong buffering: one bank fills while the other drains, so back-to-back blocks need no gap.
- Interleaved addresses come from an incremental QPP recursion, not a wide combinational remap.

---
 rtl/qpp_block_interleaver.sv | 182 ++++++++++++++++++
 tb/tb_qpp_block_interleaver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/qpp_block_interleaver.sv
// qpp_block_interleaver: ping-pong buffered QPP interleaver. Code blocks arrive
// as DATA_W-bit words, fill one bank while the other drains, and leave as two
// bit-serial streams: c[i] in natural order and c[pi(i)] in QPP order.
module qpp_block_interleaver #(
    parameter int DATA_W = 8,
    parameter int MAX_K  = 6144,
    parameter int K0     = 1056,
    parameter int F1_0   = 17,
    parameter int F2_0   = 66,
    parameter int K1     = 6144,
    parameter int F1_1   = 263,
    parameter int F2_1   = 480,
    parameter int AW     = 13
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              k_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_i,
    output logic              out_pii,
    output logic              out_first,
    output logic              out_last,
    output logic              out_k_sel
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

    // Issue-stage request: which bank, which index, and the QPP recursion state.
    typedef struct packed {
        logic          bank;
        logic          ksel;
        logic          first;
        logic          last;
        logic [AW-1:0] idx;
        logic [AW-1:0] pi;
        logic [AW-1:0] g;
    } rd_req_t;

    localparam int STAGES = 1;

    // Block constants; g(0) and the 2*f2 step are reduced mod K here so the
    // recursion only ever adds two operands below K.
    localparam logic [AW:0]   KL0 = (AW+1)'(K0);
    localparam logic [AW:0]   KL1 = (AW+1)'(K1);
    localparam logic [AW:0]   KW0 = (AW+1)'(K0 / DATA_W);
    localparam logic [AW:0]   KW1 = (AW+1)'(K1 / DATA_W);
    localparam logic [AW-1:0] G0_0 = AW'((F1_0 + F2_0) % K0);
    localparam logic [AW-1:0] G0_1 = AW'((F1_1 + F2_1) % K1);
    localparam logic [AW-1:0] D_0  = AW'((2 * F2_0) % K0);
    localparam logic [AW-1:0] D_1  = AW'((2 * F2_1) % K1);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam logic [AW:0]   TWO  = (AW+1)'(2);

    function automatic logic [AW:0] kval(input logic s);
        return s ? KL1 : KL0;
    endfunction

    function automatic logic [AW:0] kwords(input logic s);
        return s ? KW1 : KW0;
    endfunction

    function automatic logic [AW-1:0] g0v(input logic s);
        return s ? G0_1 : G0_0;
    endfunction

    function automatic logic [AW-1:0] dv(input logic s);
        return s ? D_1 : D_0;
    endfunction

    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW:0]   k);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= k) s = s - k;
        return s[AW-1:0];
    endfunction

    logic [MAX_K-1:0] mem [2];
    bank_st_t         st [2];
    bank_st_t         st_nx [2];
    logic [1:0]       bksel;
    logic             wr_bank, wr_bank_nx, rd_sel, o_bank;
    logic [AW-1:0]    wcnt;
    logic [AW-1:0]    wbase;
    rd_req_t          s1;
    logic [AW:0]      s1_k;
    logic [STAGES:0]  vld_pipe;
    logic             adv, accept, wsel, wlast, start, done, in_ready_nx;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign accept    = in_valid && in_ready;
    assign wsel      = (st[wr_bank] == EMPTY) ? k_sel : bksel[wr_bank];
    assign wlast     = ({1'b0, wcnt} + ONE) == kwords(wsel);
    assign wbase     = AW'(wcnt * DATA_W);
    assign s1_k      = kval(s1.ksel);
    // A new block may be issued when the issue stage is idle or emitting its last index.
    assign start     = adv && (!vld_pipe[0] || s1.last) && (st[rd_sel] == FULL);
    assign done      = vld_pipe[STAGES] && out_ready && out_last;

    // Next bank states; write and read events touch disjoint states, so they never collide.
    always_comb begin
        st_nx = st;
        for (int b = 0; b < 2; b++) begin
            if (accept && wr_bank == 1'(b)) st_nx[b] = wlast ? FULL : FILLING;
            if (start && rd_sel == 1'(b))   st_nx[b] = DRAINING;
            if (done && o_bank == 1'(b))    st_nx[b] = EMPTY;
        end
        wr_bank_nx  = wr_bank ^ (accept && wlast);
        in_ready_nx = (st_nx[wr_bank_nx] == EMPTY) || (st_nx[wr_bank_nx] == FILLING);
    end

    // Bank storage: word-wide writes, two independent bit reads of the same bank.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wbase +: DATA_W] <= in_data;
    end

    // Bank bookkeeping, write pointer, issue stage and registered outputs.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            st[0]     <= EMPTY;
            st[1]     <= EMPTY;
            bksel     <= '0;
            wr_bank   <= 1'b0;
            wcnt      <= '0;
            rd_sel    <= 1'b0;
            o_bank    <= 1'b0;
            s1        <= '0;
            vld_pipe  <= '0;
            in_ready  <= 1'b0;
            out_i     <= 1'b0;
            out_pii   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_k_sel <= 1'b0;
        end else begin
            st       <= st_nx;
            wr_bank  <= wr_bank_nx;
            in_ready <= in_ready_nx;
            if (accept) begin
                if (st[wr_bank] == EMPTY) bksel[wr_bank] <= k_sel;
                wcnt <= wlast ? '0 : wcnt + 1'b1;
            end
            if (adv) begin
                vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
                if (vld_pipe[0]) begin
                    out_i     <= mem[s1.bank][s1.idx];
                    out_pii   <= mem[s1.bank][s1.pi];
                    out_first <= s1.first;
                    out_last  <= s1.last;
                    out_k_sel <= s1.ksel;
                    o_bank    <= s1.bank;
                end
                if (start) begin
                    s1.bank     <= rd_sel;
                    s1.ksel     <= bksel[rd_sel];
                    s1.first    <= 1'b1;
                    s1.last     <= kval(bksel[rd_sel]) == ONE;
                    s1.idx      <= '0;
                    s1.pi       <= '0;
                    s1.g        <= g0v(bksel[rd_sel]);
                    vld_pipe[0] <= 1'b1;
                    rd_sel      <= ~rd_sel;
                end else if (vld_pipe[0] && !s1.last) begin
                    s1.first <= 1'b0;
                    s1.last  <= ({1'b0, s1.idx} + TWO) == s1_k;
                    s1.idx   <= s1.idx + 1'b1;
                    s1.pi    <= mod_add(s1.pi, s1.g, s1_k);
                    s1.g     <= mod_add(s1.g, dv(s1.ksel), s1_k);
                end else begin
                    vld_pipe[0] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qpp_block_interleaver.sv
// tb_qpp_block_interleaver: directed blocks streamed through the interleaver,
// outputs checked against a closed-form QPP model and hand-computed values.
module tb_qpp_block_interleaver;

    localparam int LIM = 40000;

    logic       clk, aclr_n, k_sel, in_valid, in_ready, out_ready;
    logic       out_valid, out_i, out_pii, out_first, out_last, out_k_sel;
    logic [7:0] in_data;

    int n_cmp = 0, n_err = 0, cyc_g = 0, t_acc = 0, t_fv = 0, stalls = 0;
    logic [6143:0] blk_data [3];
    logic          blk_sel  [3];
    logic          pii0     [4];

    qpp_block_interleaver dut (
        .clk(clk), .aclr_n(aclr_n), .k_sel(k_sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .out_i(out_i), .out_pii(out_pii),
        .out_first(out_first), .out_last(out_last), .out_k_sel(out_k_sel)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;
    // Edge counter used for latency and gap measurements.
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int kof(input logic sel);
        return sel ? 6144 : 1056;
    endfunction

    function automatic int pi_of(input logic sel, input int i);
        longint f1, f2, kk, ii;
        f1 = sel ? 263 : 17;
        f2 = sel ? 480 : 66;
        kk = kof(sel);
        ii = i;
        return int'((f1 * ii + f2 * ii * ii) % kk);
    endfunction

    task automatic fill(input int b, input logic sel, input int mode);
        int nw;
        int t;
        logic [7:0] v;
        nw = kof(sel) / 8;
        blk_sel[b]  = sel;
        blk_data[b] = '0;
        for (int w = 0; w < nw; w++) begin
            t = w * 29 + mode * 13 + (w >> 2);
            if (mode == 0) v = 8'h01;
            else if (mode == 1) v = w[7:0];
            else v = t[7:0];
            blk_data[b][w*8 +: 8] = v;
        end
    endtask

    task automatic feed(input int nb);
        int guard, tot, want, nw, w;
        logic acc;
        guard = 0; tot = 0; want = 0; stalls = 0;
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            nw = kof(blk_sel[b]) / 8;
            want += nw;
            w = 0;
            k_sel    = blk_sel[b];
            in_data  = blk_data[b][7:0];
            in_valid = 1'b1;
            while (w < nw && guard < LIM) begin
                acc = in_ready;
                if (!acc) stalls++;
                if (acc && w == nw - 1) t_acc = cyc_g + 1;
                @(negedge clk);
                guard++;
                if (acc) begin
                    w++;
                    tot++;
                    if (w == 1) k_sel = ~blk_sel[b];
                    if (w < nw) in_data = blk_data[b][w*8 +: 8];
                end
            end
        end
        in_valid = 1'b0;
        chk("feed_words", tot, want);
    endtask

    task automatic drain(input int nb, input int stall_at, input int abort_at, input bit chk_gap);
        int b, i, guard, rem, last_cyc, k, p, e_i, e_p, e_f, e_k;
        bit seen, stalled;
        logic [5:0] snap;
        b = 0; i = 0; guard = 0; rem = 0; last_cyc = 0;
        e_i = 0; e_p = 0; e_f = 0; e_k = 0;
        seen = 0; stalled = 0; snap = '0;
        out_ready = 1'b1;
        while (b < nb && guard < LIM) begin
            @(negedge clk);
            guard++;
            if (!out_valid) continue;
            if (!seen) begin
                seen = 1;
                t_fv = cyc_g;
            end
            if (abort_at >= 0 && i == abort_at) begin
                aclr_n = 1'b0;
                #1;
                chk("rst_mid_out_valid", out_valid, 0);
                chk("rst_mid_in_ready", in_ready, 0);
                chk("rst_mid_out_first", out_first, 0);
                chk("rst_mid_out_last", out_last, 0);
                return;
            end
            if (rem > 0) begin
                chk("stall_hold", {out_valid, out_i, out_pii, out_first, out_last, out_k_sel}, snap);
                rem--;
                if (rem > 0) continue;
                out_ready = 1'b1;
            end else if (i == stall_at && !stalled) begin
                stalled   = 1;
                snap      = {out_valid, out_i, out_pii, out_first, out_last, out_k_sel};
                out_ready = 1'b0;
                rem       = 3;
                continue;
            end
            k = kof(blk_sel[b]);
            p = pi_of(blk_sel[b], i);
            if (out_i !== blk_data[b][i]) e_i++;
            if (out_pii !== blk_data[b][p]) e_p++;
            if (out_first !== (i == 0) || out_last !== (i == k - 1)) e_f++;
            if (out_k_sel !== blk_sel[b]) e_k++;
            if (b == 0 && i < 4) pii0[i] = out_pii;
            if (i == 0 && b > 0 && chk_gap) chk("gap_cycles", cyc_g - last_cyc, 1);
            if (i == k - 1) begin
                chk($sformatf("blk%0d_out_i_errs", b), e_i, 0);
                chk($sformatf("blk%0d_out_pii_errs", b), e_p, 0);
                chk($sformatf("blk%0d_first_last_errs", b), e_f, 0);
                chk($sformatf("blk%0d_k_sel_errs", b), e_k, 0);
                e_i = 0; e_p = 0; e_f = 0; e_k = 0;
                last_cyc = cyc_g;
                b++;
                i = 0;
            end else begin
                i++;
            end
        end
        chk("drain_blocks", b, nb);
    endtask

    // Directed test sequence.
    initial begin
        logic exp1 [4];
        logic exp2 [4];
        exp1 = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp2 = '{1'b0, 1'b0, 1'b0, 1'b1};
        aclr_n = 1'b0; k_sel = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_pii", out_pii, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_k_sel", out_k_sel, 0);
        aclr_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_up", in_ready, 1);

        // K0 block of 8'h01 words
        fill(0, 1'b0, 0);
        fork feed(1); drain(1, -1, -1, 1'b0); join
        chk("t1_latency", t_fv - t_acc, 2);
        for (int j = 0; j < 4; j++) chk($sformatf("t1_pii%0d", j), pii0[j], exp1[j]);

        // K1 block of incrementing words
        fill(0, 1'b1, 1);
        fork feed(1); drain(1, -1, -1, 1'b0); join
        for (int j = 0; j < 4; j++) chk($sformatf("t2_pii%0d", j), pii0[j], exp2[j]);

        // K0 then K1 back to back
        fill(0, 1'b0, 5);
        fill(1, 1'b1, 6);
        fork feed(2); drain(2, -1, -1, 1'b1); join
        chk("t3_in_ready_stalls", stalls, 0);

        // Downstream stall at i=500
        fill(0, 1'b0, 7);
        fork feed(1); drain(1, 500, -1, 1'b0); join

        // Three K1 blocks offered continuously
        fill(0, 1'b1, 8);
        fill(1, 1'b1, 9);
        fill(2, 1'b1, 10);
        fork feed(3); drain(3, -1, -1, 1'b1); join
        chk("t5_in_ready_dropped", stalls > 0, 1);

        // Reset mid-drain, then a fresh block
        fill(0, 1'b0, 11);
        fork feed(1); drain(1, -1, 200, 1'b0); join
        repeat (2) @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
        chk("t6_in_ready_up", in_ready, 1);
        fill(0, 1'b0, 12);
        fork feed(1); drain(1, -1, -1, 1'b0); join
        chk("t6_latency", t_fv - t_acc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
